clint_ctrl: RTL

- Core-local interrupt/exception sequencer for the 5-stage RV32I pipeline.
- Sits upstream of the pipeline controller and drives its hold_flag_clint_i input.
- Detects ECALL, EBREAK and MRET in the decode stage, and detects the qualified external timer interrupt.
- Stalls the pipeline, performs the machine-mode CSR writes in sequence, then issues a redirect to the trap vector or to the saved return address.

---
 rtl/clint_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/clint_ctrl.sv
// Core-local trap sequencer: detects ECALL/EBREAK/MRET and qualified timer interrupts,
// holds the pipeline while the machine CSRs are written, then strobes a redirect.
module clint_ctrl #(
  parameter logic [11:0] MTVEC_ADDR   = 12'h305,
  parameter logic [11:0] MEPC_ADDR    = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR  = 12'h342,
  parameter logic [11:0] MSTATUS_ADDR = 12'h300
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        int_flag_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        hold_flag_o,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  // mtvec is read through csr_mtvec_i; its address only has to stay distinct.
  if (MTVEC_ADDR == MEPC_ADDR || MTVEC_ADDR == MCAUSE_ADDR || MTVEC_ADDR == MSTATUS_ADDR) begin : g_bad_cfg
    $error("clint_ctrl: CSR addresses must be distinct");
  end

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  typedef enum logic [2:0] {
    IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, W_MRET_MSTATUS, ASSERT
  } state_e;

  state_e      state_q;
  logic [31:0] cause_q, mstatus_q, target_q;
  logic        csr_we_q, int_assert_q;
  logic [11:0] csr_waddr_q;
  logic [31:0] csr_wdata_q, int_addr_q;

  logic        is_ecall, is_ebreak, is_mret, async_req, exc_now, trap_now;
  logic [31:0] epc_d, cause_d;

  assign is_ecall  = (inst_i == INST_ECALL);
  assign is_ebreak = (inst_i == INST_EBREAK);
  assign is_mret   = (inst_i == INST_MRET);
  assign async_req = int_flag_i & csr_mstatus_i[3];
  assign exc_now   = is_ecall | is_ebreak;
  assign trap_now  = exc_now | async_req;

  // An interrupt resumes at the branch target when EX is redirecting this cycle.
  assign epc_d   = (!exc_now && br_taken_i) ? br_target_i : inst_addr_i;
  assign cause_d = is_ecall ? 32'd11 : is_ebreak ? 32'd3 : 32'h8000_0007;

  function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
    logic [31:0] m;
    m    = s;
    m[7] = s[3];
    m[3] = 1'b0;
    return m;
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
    logic [31:0] m;
    m    = s;
    m[3] = s[7];
    m[7] = 1'b1;
    return m;
  endfunction

  assign hold_flag_o  = (state_q != IDLE) | trap_now | is_mret;
  assign csr_we_o     = csr_we_q;
  assign csr_waddr_o  = csr_waddr_q;
  assign csr_wdata_o  = csr_wdata_q;
  assign int_assert_o = int_assert_q;
  assign int_addr_o   = int_addr_q;

  // Outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cause_q      <= '0;
      mstatus_q    <= '0;
      target_q     <= '0;
      csr_we_q     <= 1'b0;
      csr_waddr_q  <= '0;
      csr_wdata_q  <= '0;
      int_assert_q <= 1'b0;
      int_addr_q   <= '0;
    end else begin
      csr_we_q     <= 1'b0;
      csr_waddr_q  <= '0;
      csr_wdata_q  <= '0;
      int_assert_q <= 1'b0;
      int_addr_q   <= '0;
      case (state_q)
        IDLE: begin
          if (trap_now) begin
            cause_q     <= cause_d;
            mstatus_q   <= csr_mstatus_i;
            target_q    <= csr_mtvec_i;
            state_q     <= W_MEPC;
            csr_we_q    <= 1'b1;
            csr_waddr_q <= MEPC_ADDR;
            csr_wdata_q <= epc_d;
          end else if (is_mret) begin
            mstatus_q   <= csr_mstatus_i;
            target_q    <= csr_mepc_i;
            state_q     <= W_MRET_MSTATUS;
            csr_we_q    <= 1'b1;
            csr_waddr_q <= MSTATUS_ADDR;
            csr_wdata_q <= mret_mstatus(csr_mstatus_i);
          end
        end
        W_MEPC: begin
          state_q     <= W_MCAUSE;
          csr_we_q    <= 1'b1;
          csr_waddr_q <= MCAUSE_ADDR;
          csr_wdata_q <= cause_q;
        end
        W_MCAUSE: begin
          state_q     <= W_MSTATUS;
          csr_we_q    <= 1'b1;
          csr_waddr_q <= MSTATUS_ADDR;
          csr_wdata_q <= trap_mstatus(mstatus_q);
        end
        W_MSTATUS, W_MRET_MSTATUS: begin
          state_q      <= ASSERT;
          int_assert_q <= 1'b1;
          int_addr_q   <= target_q;
        end
        ASSERT:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
